// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the kanade32 decode/execute boundary: ALU op codes,
// primary opcodes and R-type funct values.
package id_ex_stage_pkg;

    localparam logic [2:0] ALU_OP_AND     = 3'b000;
    localparam logic [2:0] ALU_OP_OR      = 3'b001;
    localparam logic [2:0] ALU_OP_ADD     = 3'b010;
    localparam logic [2:0] ALU_OP_SUB_NOT = 3'b011;
    localparam logic [2:0] ALU_OP_SUB     = 3'b110;
    localparam logic [2:0] ALU_OP_SLT     = 3'b111;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/id_ex_stage_alu_ctrl.sv
// Combinational ALU-control decoder: opcode/funct to ALU op, operand-B source
// and the control flags carried down the pipe.
module alu_ctrl
    import id_ex_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       imm_zext,
    output logic       use_imm,
    output logic       reg_write,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       branch,
    output logic       illegal
);

    always_comb begin
        alu_op    = ALU_OP_ADD;
        imm_zext  = 1'b0;
        use_imm   = 1'b0;
        reg_write = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        branch    = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_OP_ADD;
                    FN_SUB:  alu_op = ALU_OP_SUB;
                    FN_AND:  alu_op = ALU_OP_AND;
                    FN_OR:   alu_op = ALU_OP_OR;
                    FN_SLT:  alu_op = ALU_OP_SLT;
                    default: begin
                        reg_write = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OPC_ADDI: begin
                use_imm   = 1'b1;
                reg_write = 1'b1;
            end
            OPC_SLTI: begin
                alu_op    = ALU_OP_SLT;
                use_imm   = 1'b1;
                reg_write = 1'b1;
            end
            OPC_ANDI: begin
                alu_op    = ALU_OP_AND;
                use_imm   = 1'b1;
                imm_zext  = 1'b1;
                reg_write = 1'b1;
            end
            OPC_ORI: begin
                alu_op    = ALU_OP_OR;
                use_imm   = 1'b1;
                imm_zext  = 1'b1;
                reg_write = 1'b1;
            end
            OPC_LW: begin
                use_imm   = 1'b1;
                reg_write = 1'b1;
                mem_rd    = 1'b1;
            end
            OPC_SW: begin
                use_imm = 1'b1;
                mem_wr  = 1'b1;
            end
            OPC_BEQ: begin
                alu_op = ALU_OP_SUB;
                branch = 1'b1;
            end
            OPC_BNE: begin
                alu_op = ALU_OP_SUB_NOT;
                branch = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for kanade32: captures decoded operands, forwards
// write-back results at capture and keeps snooping them while the ALU stalls.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_rs_data,
    input  logic [XLEN-1:0]   id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic              wb0_we,
    input  logic [REG_AW-1:0] wb0_rd,
    input  logic [XLEN-1:0]   wb0_data,
    input  logic              wb1_we,
    input  logic [REG_AW-1:0] wb1_rd,
    input  logic [XLEN-1:0]   wb1_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [2:0]        alu_op,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_branch,
    output logic [XLEN-1:0]   ex_rt_data,
    output logic              ex_illegal
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; a producer holding valid keeps its payload stable until that edge.
    logic capture, hold;
    assign id_ready = !ex_valid || ex_ready;
    assign capture  = id_valid && id_ready;
    assign hold     = ex_valid && !ex_ready;

    logic [2:0] dec_op;
    logic       dec_zext, dec_use_imm, dec_rw, dec_mr, dec_mw, dec_br, dec_ill;

    alu_ctrl u_alu_ctrl (
        .opcode    (id_opcode),
        .funct     (id_funct),
        .alu_op    (dec_op),
        .imm_zext  (dec_zext),
        .use_imm   (dec_use_imm),
        .reg_write (dec_rw),
        .mem_rd    (dec_mr),
        .mem_wr    (dec_mw),
        .branch    (dec_br),
        .illegal   (dec_ill)
    );

    // EX/MEM port wins over MEM/WB; r0 is hard-wired and never overridden.
    function automatic logic [XLEN-1:0] fwd(
        input logic [REG_AW-1:0] src,
        input logic [XLEN-1:0]   dflt,
        input logic              w0_we,
        input logic [REG_AW-1:0] w0_rd,
        input logic [XLEN-1:0]   w0_data,
        input logic              w1_we,
        input logic [REG_AW-1:0] w1_rd,
        input logic [XLEN-1:0]   w1_data
    );
        if (src == '0)                     return dflt;
        else if (w0_we && (w0_rd == src))  return w0_data;
        else if (w1_we && (w1_rd == src))  return w1_data;
        else                               return dflt;
    endfunction

    logic [REG_AW-1:0] rs_tag, rt_tag;
    logic              b_is_reg;
    logic [XLEN-1:0]   rs_fwd, rt_fwd, rs_snp, rt_snp, imm_ext;

    always_comb begin
        rs_fwd  = fwd(id_rs, id_rs_data, wb0_we, wb0_rd, wb0_data, wb1_we, wb1_rd, wb1_data);
        rt_fwd  = fwd(id_rt, id_rt_data, wb0_we, wb0_rd, wb0_data, wb1_we, wb1_rd, wb1_data);
        rs_snp  = fwd(rs_tag, alu_a, wb0_we, wb0_rd, wb0_data, wb1_we, wb1_rd, wb1_data);
        rt_snp  = fwd(rt_tag, ex_rt_data, wb0_we, wb0_rd, wb0_data, wb1_we, wb1_rd, wb1_data);
        imm_ext = dec_zext ? {{(XLEN-16){1'b0}}, id_imm} : {{(XLEN-16){id_imm[15]}}, id_imm};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            alu_op       <= ALU_OP_AND;
            alu_a        <= '0;
            alu_b        <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_rd    <= 1'b0;
            ex_mem_wr    <= 1'b0;
            ex_branch    <= 1'b0;
            ex_rt_data   <= '0;
            ex_illegal   <= 1'b0;
            rs_tag       <= '0;
            rt_tag       <= '0;
            b_is_reg     <= 1'b0;
        end else begin
            if (flush)        ex_valid <= 1'b0;
            else if (capture) ex_valid <= 1'b1;
            else if (ex_ready) ex_valid <= 1'b0;

            if (capture) begin
                alu_op       <= dec_op;
                alu_a        <= rs_fwd;
                alu_b        <= dec_use_imm ? imm_ext : rt_fwd;
                ex_rd        <= id_rd;
                ex_reg_write <= dec_rw;
                ex_mem_rd    <= dec_mr;
                ex_mem_wr    <= dec_mw;
                ex_branch    <= dec_br;
                ex_rt_data   <= rt_fwd;
                ex_illegal   <= dec_ill;
                rs_tag       <= id_rs;
                rt_tag       <= id_rt;
                b_is_reg     <= !dec_use_imm;
            end else if (hold) begin
                // A stalled instruction must still see results retiring behind it.
                alu_a      <= rs_snp;
                ex_rt_data <= rt_snp;
                if (b_is_reg) alu_b <= rt_snp;
            end
        end
    end

endmodule
